jtag_led_frame_arbiter: RTL and testbench

- Shares one 4-row RGB frame buffer between the two JTAG user-chain datapaths (chain 1 and chain 2). Each chain issues row writes over a valid/ack handshake.
- Scans the stored frame onto the LED matrix: one row at a time, with a one-hot row enable and inter-row blanking.
- Sits between the chain1/chain2 register logic and the top-level red/blue/green/rgbRow pins, replacing their direct LED drive.
- Runs entirely in the JTAG clock domain.

---
 rtl/jtag_led_frame_arbiter_if.sv | 29 ++
 rtl/jtag_led_frame_arbiter.sv | 96 +++++++++
 tb/tb_jtag_led_frame_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_led_frame_arbiter_if.sv
// Row-write handshake bundle between the two JTAG user chains and the
// frame-buffer arbiter. Chain side is the master, arbiter side the slave.
interface jtag_led_frame_arbiter_if #(
  parameter int ROW_W   = 2,
  parameter int COLOR_W = 30
);
  logic               req1_valid;
  logic [ROW_W-1:0]   req1_row;
  logic [COLOR_W-1:0] req1_data;
  logic               req1_ack;
  logic               req2_valid;
  logic [ROW_W-1:0]   req2_row;
  logic [COLOR_W-1:0] req2_data;
  logic               req2_ack;

  modport master (
    output req1_valid, req1_row, req1_data,
    input  req1_ack,
    output req2_valid, req2_row, req2_data,
    input  req2_ack
  );

  modport slave (
    input  req1_valid, req1_row, req1_data,
    output req1_ack,
    input  req2_valid, req2_row, req2_data,
    output req2_ack
  );
endinterface

// File: rtl/jtag_led_frame_arbiter.sv
// Round-robin arbiter sharing a NUM_ROWS RGB frame buffer between JTAG chains
// 1 and 2, plus a row scanner driving the LED matrix with inter-row blanking.
module jtag_led_frame_arbiter #(
  parameter int NUM_ROWS = 4,
  parameter int ROW_W    = 2,
  parameter int COLOR_W  = 30,
  parameter int SCAN_DIV = 1024,
  parameter int BLANK    = 16
) (
  input  logic                 JTCK,
  input  logic                 JRSTN,
  jtag_led_frame_arbiter_if.slave req,
  input  logic                 scan_en,
  output logic [COLOR_W-1:0]   LEDS,
  output logic [NUM_ROWS-1:0]  rgbRow,
  output logic [ROW_W-1:0]     cur_row
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);

  localparam logic PTR_CHAIN1 = 1'b0;
  localparam logic PTR_CHAIN2 = 1'b1;

  logic [COLOR_W-1:0] frame [NUM_ROWS];
  logic               ptr;
  logic               elig1, elig2, grant1, grant2;
  logic [DIV_W-1:0]   div_cnt, div_next;
  logic [ROW_W-1:0]   row_next;

  // A requester whose ack is currently high is skipped, so a held valid
  // cannot be granted twice for the same word.
  always_comb begin
    elig1  = req.req1_valid & ~req.req1_ack;
    elig2  = req.req2_valid & ~req.req2_ack;
    grant1 = elig1 & (~elig2 | (ptr == PTR_CHAIN1));
    grant2 = elig2 & ~grant1;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the branches leaves it unassigned and infers a latch.
    div_next = '0;
    row_next = '0;
    if (scan_en) begin
      if (div_cnt == DIV_LAST) begin
        div_next = '0;
        row_next = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        div_next = div_cnt + DIV_W'(1);
        row_next = cur_row;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every block sees
  // pre-edge values; the scanner relies on this to read the old frame word.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      ptr          <= PTR_CHAIN1;
      req.req1_ack <= 1'b0;
      req.req2_ack <= 1'b0;
      // NOTE: the frame is reset explicitly because a blank matrix after
      // reset is visible behaviour; this keeps it in flops, not RAM.
      for (int i = 0; i < NUM_ROWS; i++) frame[i] <= '0;
    end else begin
      req.req1_ack <= grant1;
      req.req2_ack <= grant2;
      if (grant1) begin
        frame[req.req1_row] <= req.req1_data;
        ptr                 <= PTR_CHAIN2;
      end else if (grant2) begin
        frame[req.req2_row] <= req.req2_data;
        ptr                 <= PTR_CHAIN1;
      end
    end
  end

  // Outputs follow the next scan position so rgbRow and cur_row always agree.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      div_cnt <= '0;
      cur_row <= '0;
      rgbRow  <= '0;
      LEDS    <= '0;
    end else begin
      div_cnt <= div_next;
      cur_row <= row_next;
      rgbRow  <= scan_en ? (NUM_ROWS'(1) << row_next) : '0;
      LEDS    <= (scan_en && (div_next >= BLANK_END)) ? frame[row_next] : '0;
    end
  end

endmodule

// File: tb/tb_jtag_led_frame_arbiter.sv
// Directed bench for jtag_led_frame_arbiter: a timeline-based reference model
// checked every cycle, plus hand-computed spot values.
module tb_jtag_led_frame_arbiter;
  localparam int NUM_ROWS = 4;
  localparam int ROW_W    = 2;
  localparam int COLOR_W  = 30;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;

  logic                JTCK = 1'b0;
  logic                JRSTN = 1'b0;
  logic                scan_en = 1'b0;
  logic [COLOR_W-1:0]  LEDS;
  logic [NUM_ROWS-1:0] rgbRow;
  logic [ROW_W-1:0]    cur_row;

  jtag_led_frame_arbiter_if #(.ROW_W(ROW_W), .COLOR_W(COLOR_W)) bus ();

  jtag_led_frame_arbiter #(
    .NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W), .COLOR_W(COLOR_W),
    .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)
  ) dut (
    .JTCK(JTCK), .JRSTN(JRSTN), .req(bus), .scan_en(scan_en),
    .LEDS(LEDS), .rgbRow(rgbRow), .cur_row(cur_row)
  );

  always #5 JTCK = ~JTCK;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan position derives from m_t, the number of enabled edges since
  // scanning (re)started; arbitration remembers the last chain granted.
  logic [COLOR_W-1:0] m_frame [NUM_ROWS];
  logic [COLOR_W-1:0] m_leds;
  int                 m_t, m_last, m_win;
  bit                 m_ack1, m_ack2;

  function automatic int pick_winner(input bit e1, input bit e2, input int last);
    if (e1 && e2) return (last == 1) ? 2 : 1;
    if (e1) return 1;
    if (e2) return 2;
    return 0;
  endfunction

  function automatic logic [COLOR_W-1:0] leds_at(input int t);
    int div, row;
    div = t % SCAN_DIV;
    row = (t / SCAN_DIV) % NUM_ROWS;
    return (div < BLANK) ? '0 : m_frame[row];
  endfunction

  always_comb m_win = pick_winner(bus.req1_valid && !m_ack1, bus.req2_valid && !m_ack2, m_last);

  always @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      for (int i = 0; i < NUM_ROWS; i++) m_frame[i] <= '0;
      m_t    <= 0;
      m_leds <= '0;
      m_ack1 <= 1'b0;
      m_ack2 <= 1'b0;
      m_last <= 2;
    end else begin
      m_ack1 <= (m_win == 1);
      m_ack2 <= (m_win == 2);
      if (m_win != 0) m_last <= m_win;
      if (m_win == 1) m_frame[bus.req1_row] <= bus.req1_data;
      else if (m_win == 2) m_frame[bus.req2_row] <= bus.req2_data;
      if (scan_en) begin
        m_t    <= m_t + 1;
        m_leds <= leds_at(m_t + 1);
      end else begin
        m_t    <= 0;
        m_leds <= '0;
      end
    end
  end

  always @(negedge JTCK) begin
    if (cmp_en && JRSTN) begin
      int exp_row;
      exp_row = (m_t / SCAN_DIV) % NUM_ROWS;
      check("model_ack1", 32'(bus.req1_ack), 32'(m_ack1));
      check("model_ack2", 32'(bus.req2_ack), 32'(m_ack2));
      check("model_leds", 32'(LEDS), 32'(m_leds));
      check("model_cur_row", 32'(cur_row), 32'(exp_row));
      check("model_rgbrow", 32'(rgbRow), (m_t == 0) ? 32'd0 : (32'd1 << exp_row));
    end
  end

  task automatic drive(input int ch, input bit v, input logic [ROW_W-1:0] row,
                       input logic [COLOR_W-1:0] data);
    if (ch == 1) begin
      bus.req1_valid = v; bus.req1_row = row; bus.req1_data = data;
    end else begin
      bus.req2_valid = v; bus.req2_row = row; bus.req2_data = data;
    end
  endtask

  task automatic do_write(input int ch, input logic [ROW_W-1:0] row,
                          input logic [COLOR_W-1:0] data);
    bit seen;
    seen = 1'b0;
    @(negedge JTCK);
    drive(ch, 1'b1, row, data);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge JTCK);
      seen = (ch == 1) ? bus.req1_ack : bus.req2_ack;
    end
    drive(ch, 1'b0, row, data);
    check("write_ack_seen", 32'(seen), 32'd1);
    @(negedge JTCK);
    check("write_ack_one_cycle", 32'((ch == 1) ? bus.req1_ack : bus.req2_ack), 32'd0);
  endtask

  int ack_cnt, nz_cnt;
  bit seen_ack;

  initial begin
    drive(1, 1'b0, '0, '0);
    drive(2, 1'b0, '0, '0);
    repeat (2) @(negedge JTCK);
    JRSTN  = 1'b1;
    cmp_en = 1'b1;
    @(negedge JTCK);
    check("reset_leds", 32'(LEDS), 32'd0);
    check("reset_rgbrow", 32'(rgbRow), 32'd0);
    check("reset_cur_row", 32'(cur_row), 32'd0);

    // Simultaneous requests with the pointer on chain 1: chain 1, then chain 2.
    @(negedge JTCK);
    drive(1, 1'b1, 2'd0, 30'h1);
    drive(2, 1'b1, 2'd0, 30'h2);
    @(negedge JTCK);
    check("sim1_first_ack1", 32'(bus.req1_ack), 32'd1);
    check("sim1_first_ack2", 32'(bus.req2_ack), 32'd0);
    drive(1, 1'b0, 2'd0, 30'h1);
    @(negedge JTCK);
    check("sim1_second_ack1", 32'(bus.req1_ack), 32'd0);
    check("sim1_second_ack2", 32'(bus.req2_ack), 32'd1);
    drive(2, 1'b0, 2'd0, 30'h2);
    @(negedge JTCK);

    // Lone chain-1 write moves the pointer to chain 2.
    do_write(1, 2'd2, 30'h3FF);

    @(negedge JTCK);
    drive(1, 1'b1, 2'd0, 30'h1);
    drive(2, 1'b1, 2'd0, 30'h2);
    @(negedge JTCK);
    check("sim2_first_ack2", 32'(bus.req2_ack), 32'd1);
    check("sim2_first_ack1", 32'(bus.req1_ack), 32'd0);
    drive(2, 1'b0, 2'd0, 30'h2);
    @(negedge JTCK);
    check("sim2_second_ack1", 32'(bus.req1_ack), 32'd1);
    drive(1, 1'b0, 2'd0, 30'h1);

    do_write(1, 2'd0, 30'h1);
    do_write(2, 2'd1, 30'h2);
    do_write(1, 2'd2, 30'h3);
    do_write(2, 2'd3, 30'h4);

    // Scan with hand-computed positions; row 2 is dropped mid-period at t=52.
    @(negedge JTCK);
    scan_en = 1'b1;
    for (int t = 1; t <= 52; t++) begin
      @(negedge JTCK);
      case (t)
        1:  begin check("scan_t1_rgb", 32'(rgbRow), 32'h1); check("scan_t1_leds", 32'(LEDS), 32'h0); end
        2:  check("scan_t2_leds", 32'(LEDS), 32'h1);
        8:  begin check("scan_t8_rgb", 32'(rgbRow), 32'h2); check("scan_t8_leds", 32'(LEDS), 32'h0); end
        10: check("scan_t10_leds", 32'(LEDS), 32'h2);
        18: begin check("scan_t18_rgb", 32'(rgbRow), 32'h4); check("scan_t18_leds", 32'(LEDS), 32'h3); end
        26: begin check("scan_t26_rgb", 32'(rgbRow), 32'h8); check("scan_t26_leds", 32'(LEDS), 32'h4); end
        32: begin check("scan_wrap_rgb", 32'(rgbRow), 32'h1); check("scan_wrap_cur_row", 32'(cur_row), 32'd0); end
        52: check("scan_t52_cur_row", 32'(cur_row), 32'd2);
        default: ;
      endcase
    end
    scan_en = 1'b0;
    @(negedge JTCK);
    check("disable_rgb", 32'(rgbRow), 32'h0);
    check("disable_leds", 32'(LEDS), 32'h0);
    @(negedge JTCK);
    scan_en = 1'b1;
    @(negedge JTCK);
    check("reenable_rgb", 32'(rgbRow), 32'h1);
    check("reenable_leds", 32'(LEDS), 32'h0);
    @(negedge JTCK);
    check("reenable_row0_leds", 32'(LEDS), 32'h1);

    // Held valid for six edges: acks after edges 1, 3 and 5 only.
    ack_cnt = 0;
    @(negedge JTCK);
    drive(1, 1'b1, 2'd3, 30'h155);
    for (int i = 0; i < 6; i++) begin
      @(negedge JTCK);
      ack_cnt += int'(bus.req1_ack);
    end
    drive(1, 1'b0, 2'd3, 30'h155);
    check("b2b_ack_count", 32'(ack_cnt), 32'd3);

    // Asynchronous reset while chain 1 is acked and scanning is live.
    @(negedge JTCK);
    drive(1, 1'b1, 2'd1, 30'h7);
    seen_ack = 1'b0;
    for (int i = 0; i < 8 && !seen_ack; i++) begin
      @(negedge JTCK);
      seen_ack = bus.req1_ack;
    end
    check("rst_pre_ack", 32'(seen_ack), 32'd1);
    #2 JRSTN = 1'b0;
    #1;
    check("rst_async_leds", 32'(LEDS), 32'h0);
    check("rst_async_rgb", 32'(rgbRow), 32'h0);
    check("rst_async_ack1", 32'(bus.req1_ack), 32'd0);
    check("rst_async_ack2", 32'(bus.req2_ack), 32'd0);
    check("rst_async_cur_row", 32'(cur_row), 32'd0);
    drive(1, 1'b0, 2'd1, 30'h7);
    @(negedge JTCK);
    JRSTN = 1'b1;
    nz_cnt = 0;
    for (int i = 0; i < 2 * NUM_ROWS * SCAN_DIV; i++) begin
      @(negedge JTCK);
      if (LEDS != '0) nz_cnt++;
    end
    check("rst_frame_cleared", 32'(nz_cnt), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
